// File: rtl/system_timer.sv
// system_timer: prescaled free-running time counter with load, tick/wrap
// pulses, sticky alarm flags per channel and a masked interrupt.
// Optional capture port set enabled by defining SYSTEM_TIMER_CAPTURE_EN.
module system_timer #(
    parameter int TIME_W     = 16,
    parameter int PRE_W      = 16,
    parameter int NUM_ALARMS = 2
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         Enable,
    input  logic [PRE_W-1:0]             Prescale,
    input  logic                         Load,
    input  logic [TIME_W-1:0]            LoadValue,
    input  logic [NUM_ALARMS*TIME_W-1:0] AlarmValue,
    input  logic [NUM_ALARMS-1:0]        AlarmClear,
    input  logic [NUM_ALARMS-1:0]        AlarmMask,
`ifdef SYSTEM_TIMER_CAPTURE_EN
    input  logic                         CaptureReq,
    output logic [TIME_W-1:0]            CaptureTime,
    output logic                         CaptureValid,
`endif
    output logic [TIME_W-1:0]            Time,
    output logic                         Tick,
    output logic                         Wrap,
    output logic [NUM_ALARMS-1:0]        AlarmFlag,
    output logic                         Irq
);

    logic [PRE_W-1:0]      r_count;
    logic [TIME_W-1:0]     r_time;
    logic                  r_tick;
    logic                  r_wrap;
    logic                  r_upd;
    logic [NUM_ALARMS-1:0] r_flag;
    logic                  r_irq;

    logic                  w_terminal;
    logic                  w_inc;
    logic                  w_time_ones;
    logic [NUM_ALARMS-1:0] w_match;
    logic [NUM_ALARMS-1:0] w_flag_next;

    // Terminal count uses >= so a Prescale lowered below the count fires at once.
    assign w_terminal  = Enable && (r_count >= Prescale);
    assign w_inc       = !Load && w_terminal;
    assign w_time_ones = &r_time;

    // A channel matches only on the cycle right after Time took a new value.
    always_comb begin
        w_match = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            w_match[i] = r_upd && (r_time == AlarmValue[i*TIME_W +: TIME_W]);
        end
    end

    // Set has priority over clear in the same cycle.
    assign w_flag_next = w_match | (r_flag & ~AlarmClear);

    // Prescale counter: Load restarts it, disabled cycles hold it.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_count <= '0;
        end else if (Load) begin
            r_count <= '0;
        end else if (Enable) begin
            r_count <= w_terminal ? '0 : r_count + 1'b1;
        end
    end

    // Time register: Load overrides a same-cycle increment.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_time <= '0;
        end else if (Load) begin
            r_time <= LoadValue;
        end else if (w_inc) begin
            r_time <= r_time + 1'b1;
        end
    end

    // One-cycle event pulses describing what happened to Time last edge.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
            r_upd  <= 1'b0;
        end else begin
            r_tick <= w_inc;
            r_wrap <= w_inc && w_time_ones;
            r_upd  <= Load || w_inc;
        end
    end

    // Sticky alarm flags and the masked interrupt, one cycle behind the flags.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_flag <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_flag <= w_flag_next;
            r_irq  <= |(r_flag & AlarmMask);
        end
    end

`ifdef SYSTEM_TIMER_CAPTURE_EN
    logic [TIME_W-1:0] r_cap_time;
    logic              r_cap_valid;

    // Snapshot of Time on request; Load invalidates any held snapshot.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_cap_time  <= '0;
            r_cap_valid <= 1'b0;
        end else begin
            if (CaptureReq) begin
                r_cap_time <= r_time;
            end
            if (Load) begin
                r_cap_valid <= 1'b0;
            end else if (CaptureReq) begin
                r_cap_valid <= 1'b1;
            end
        end
    end

    assign CaptureTime  = r_cap_time;
    assign CaptureValid = r_cap_valid;
`endif

    assign Time      = r_time;
    assign Tick      = r_tick;
    assign Wrap      = r_wrap;
    assign AlarmFlag = r_flag;
    assign Irq       = r_irq;

endmodule

// File: tb/tb_system_timer.sv
// Scoreboard bench for system_timer (default build, capture disabled).
module tb_system_timer;

    localparam int TW   = 16;
    localparam int PW   = 16;
    localparam int NA   = 2;
    localparam int MAXT = (1 << TW) - 1;

    logic              Clock;
    logic              Reset;
    logic              Enable;
    logic [PW-1:0]     Prescale;
    logic              Load;
    logic [TW-1:0]     LoadValue;
    logic [NA*TW-1:0]  AlarmValue;
    logic [NA-1:0]     AlarmClear;
    logic [NA-1:0]     AlarmMask;
    logic [TW-1:0]     Time;
    logic              Tick;
    logic              Wrap;
    logic [NA-1:0]     AlarmFlag;
    logic              Irq;

    system_timer #(.TIME_W(TW), .PRE_W(PW), .NUM_ALARMS(NA)) dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .Prescale(Prescale),
        .Load(Load), .LoadValue(LoadValue), .AlarmValue(AlarmValue),
        .AlarmClear(AlarmClear), .AlarmMask(AlarmMask), .Time(Time),
        .Tick(Tick), .Wrap(Wrap), .AlarmFlag(AlarmFlag), .Irq(Irq)
    );

    typedef struct {
        int          time_v;
        logic        tick;
        logic        wrap;
        logic [NA-1:0] flag;
        logic        irq;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   obs_ticks = 0;

    // Reference model state (plain integers / flags)
    int          m_time;
    int          m_cnt;
    logic        m_upd;
    logic [NA-1:0] m_flag;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_time = 0;
        m_cnt  = 0;
        m_upd  = 1'b0;
        m_flag = '0;
    endtask

    // Drive one cycle of inputs and push the expected post-edge outputs.
    task automatic step(input logic en, input int pre, input logic ld, input int lv,
                        input logic [NA*TW-1:0] av, input logic [NA-1:0] clr,
                        input logic [NA-1:0] msk);
        exp_t e;
        logic [NA-1:0] nf;
        logic upd;
        @(negedge Clock);
        Enable = en; Prescale = pre[PW-1:0]; Load = ld; LoadValue = lv[TW-1:0];
        AlarmValue = av; AlarmClear = clr; AlarmMask = msk;
        for (int i = 0; i < NA; i++) begin
            if (m_upd && (m_time == int'(av[i*TW +: TW]))) nf[i] = 1'b1;
            else if (clr[i]) nf[i] = 1'b0;
            else nf[i] = m_flag[i];
        end
        e.irq  = |(m_flag & msk);
        e.tick = 1'b0;
        e.wrap = 1'b0;
        upd    = 1'b0;
        if (ld) begin
            m_time = lv & MAXT;
            m_cnt  = 0;
            upd    = 1'b1;
        end else if (en) begin
            if (m_cnt < pre) begin
                m_cnt = m_cnt + 1;
            end else begin
                m_cnt  = 0;
                e.wrap = (m_time == MAXT);
                m_time = (m_time + 1) % (1 << TW);
                e.tick = 1'b1;
                upd    = 1'b1;
            end
        end
        m_upd    = upd;
        m_flag   = nf;
        e.time_v = m_time;
        e.flag   = nf;
        sbq.push_back(e);
    endtask

    // Monitor: compare DUT outputs against the queued expectation each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clock);
            #1;
            if (Tick) obs_ticks++;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("time",  int'(Time),      e.time_v);
                chk("tick",  int'(Tick),      int'(e.tick));
                chk("wrap",  int'(Wrap),      int'(e.wrap));
                chk("flag",  int'(AlarmFlag), int'(e.flag));
                chk("irq",   int'(Irq),       int'(e.irq));
            end
        end
    end

    initial begin
        logic [NA*TW-1:0] av;
        int pre;
        Reset = 1'b1; Enable = 0; Prescale = 0; Load = 0; LoadValue = 0;
        AlarmValue = 0; AlarmClear = 0; AlarmMask = 0;
        model_reset();
        #1 Reset = 1'b0;
        #1;
        chk("rst_time", int'(Time), 0);
        chk("rst_tick", int'(Tick), 0);
        chk("rst_wrap", int'(Wrap), 0);
        chk("rst_flag", int'(AlarmFlag), 0);
        chk("rst_irq",  int'(Irq), 0);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;

        // Prescale 3 from reset: increments on edges 4, 8, 12.
        obs_ticks = 0;
        for (int c = 0; c < 12; c++) step(1'b1, 3, 1'b0, 0, '0, '0, '0);
        @(posedge Clock); #2;
        chk("p3_time12", int'(Time), 3);
        chk("p3_ticks", obs_ticks, 3);

        // Load all-ones then roll over with Prescale 0.
        step(1'b1, 0, 1'b1, 32'hFFFF, '0, '0, '0);
        step(1'b1, 0, 1'b0, 0, '0, '0, '0);
        @(posedge Clock); #2;
        chk("wrap_time", int'(Time), 0);
        chk("wrap_pulse", int'(Wrap), 1);
        chk("wrap_tick", int'(Tick), 1);

        // Alarm channel 0 at 5, masked in; then clear while Time holds at 5.
        av = '0; av[TW-1:0] = 16'd5; av[2*TW-1:TW] = 16'hAAAA;
        step(1'b1, 0, 1'b1, 0, av, '0, 2'b01);
        for (int c = 0; c < 5; c++) step(1'b1, 0, 1'b0, 0, av, '0, 2'b01);
        step(1'b0, 0, 1'b0, 0, av, '0, 2'b01);
        step(1'b0, 0, 1'b0, 0, av, '0, 2'b01);
        @(posedge Clock); #2;
        chk("alm_flag", int'(AlarmFlag), 1);
        chk("alm_irq", int'(Irq), 1);
        step(1'b0, 0, 1'b0, 0, av, 2'b01, 2'b01);
        step(1'b0, 0, 1'b0, 0, av, '0, 2'b01);
        step(1'b0, 0, 1'b0, 0, av, '0, 2'b01);
        @(posedge Clock); #2;
        chk("alm_cleared", int'(AlarmFlag), 0);
        chk("alm_irq_off", int'(Irq), 0);
        chk("alm_hold5", int'(Time), 5);

        // Load on the prescale terminal-count cycle suppresses the increment.
        step(1'b1, 2, 1'b1, 0, '0, 2'b11, '0);
        step(1'b1, 2, 1'b0, 0, '0, '0, '0);
        step(1'b1, 2, 1'b0, 0, '0, '0, '0);
        step(1'b1, 2, 1'b1, 16'h0010, '0, '0, '0);
        @(posedge Clock); #2;
        chk("ldtc_time", int'(Time), 16'h0010);
        chk("ldtc_tick", int'(Tick), 0);
        for (int c = 0; c < 3; c++) step(1'b1, 2, 1'b0, 0, '0, '0, '0);

        // Randomized traffic.
        pre = 2;
        for (int c = 0; c < 600; c++) begin
            logic ld; int lv; logic [NA-1:0] clr;
            if ($urandom_range(0, 7) == 0) pre = $urandom_range(0, 4);
            for (int i = 0; i < NA; i++)
                av[i*TW +: TW] = TW'((m_time + $urandom_range(0, 3)) & MAXT);
            ld = ($urandom_range(0, 15) == 0);
            lv = ($urandom_range(0, 1) == 0) ? (MAXT - $urandom_range(0, 2)) : $urandom_range(0, MAXT);
            for (int i = 0; i < NA; i++) clr[i] = ($urandom_range(0, 7) == 0);
            step($urandom_range(0, 9) != 0, pre, ld, lv, av, clr, NA'($urandom_range(0, 3)));
        end

        // Asynchronous reset mid-prescale with Time = 0x1234 and an alarm pending.
        av = '0; av[TW-1:0] = 16'h1234;
        step(1'b1, 5, 1'b1, 16'h1234, av, '0, 2'b01);
        for (int c = 0; c < 3; c++) step(1'b1, 5, 1'b0, 0, av, '0, 2'b01);
        @(posedge Clock); #2;
        chk("pre_rst_time", int'(Time), 16'h1234);
        chk("pre_rst_irq", int'(Irq), 1);
        @(negedge Clock); #2;
        Reset = 1'b0;
        model_reset();
        #1;
        chk("arst_time", int'(Time), 0);
        chk("arst_tick", int'(Tick), 0);
        chk("arst_wrap", int'(Wrap), 0);
        chk("arst_flag", int'(AlarmFlag), 0);
        chk("arst_irq",  int'(Irq), 0);
        Enable = 0; Load = 0; AlarmClear = 0;
        @(negedge Clock);
        Reset = 1'b1;

        // First increment after release lands on the (Prescale+1)th edge.
        for (int c = 0; c < 6; c++) step(1'b1, 2, 1'b0, 0, '0, '0, '0);
        @(posedge Clock); #2;
        chk("post_rst_time", int'(Time), 2);

        repeat (2) @(posedge Clock);
        #2;
        chk("sb_drain", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/system_timer.md
SYSTEM_TIMER -- requirements
Module: system_timer

Interface
REQ-001 SHALL have parameter TIME_W, default 16, width of the time counter.
REQ-002 SHALL have parameter PRE_W, default 16, width of the prescale counter.
REQ-003 SHALL have parameter NUM_ALARMS, default 2, number of alarm channels (1..8).
REQ-004 Clock  input  1  system clock; all state updates on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 Enable  input  1  1 = prescaler counts; 0 = prescaler and Time hold.
REQ-007 Prescale  input  PRE_W  terminal count; tick period = Prescale+1 enabled cycles.
REQ-008 Load  input  1  1-cycle strobe loading LoadValue into Time.
REQ-009 LoadValue  input  TIME_W  value for Load.
REQ-010 AlarmValue  input  NUM_ALARMS*TIME_W  compare values, channel i at bits [i*TIME_W +: TIME_W].
REQ-011 AlarmClear  input  NUM_ALARMS  per-channel flag clear strobes.
REQ-012 AlarmMask  input  NUM_ALARMS  per-channel interrupt enable.
REQ-013 Time  output  TIME_W  registered current time.
REQ-014 Tick  output  1  registered 1-cycle pulse, high the cycle after each Time increment.
REQ-015 Wrap  output  1  registered 1-cycle pulse, high the cycle after Time rolls from all-ones to 0.
REQ-016 AlarmFlag  output  NUM_ALARMS  sticky per-channel match flags.
REQ-017 Irq  output  1  registered OR of (AlarmFlag & AlarmMask).

Function
REQ-018 On an enabled cycle with count < Prescale, count SHALL increment by 1; with count >= Prescale, count SHALL go to 0 and Time SHALL increment by 1 modulo 2^TIME_W.
REQ-019 Prescale = 0 SHALL increment Time on every enabled cycle; lowering Prescale below count SHALL fire on the next enabled cycle.
REQ-020 Enable = 0 SHALL freeze count and Time; Tick and Wrap SHALL be 0.
REQ-021 Load SHALL set Time to LoadValue and count to 0 regardless of Enable, overriding a same-cycle increment; no Tick or Wrap for that cycle.
REQ-022 AlarmFlag[i] SHALL set the cycle after Time takes a new value (increment or Load) equal to AlarmValue[i]; an unchanged Time SHALL NOT re-set a cleared flag.
REQ-023 AlarmClear[i] SHALL clear AlarmFlag[i]; a same-cycle set SHALL win over the clear.
REQ-024 Irq SHALL lag AlarmFlag/AlarmMask by one cycle.

Reset
REQ-025 Reset low SHALL immediately force count, Time, Tick, Wrap, AlarmFlag, Irq (and Capture state) to 0, including mid-prescale.
REQ-026 First increment after Reset release with Enable high SHALL occur on the (Prescale+1)th rising edge.

Configuration
REQ-027 With macro SYSTEM_TIMER_CAPTURE_EN defined, SHALL add input CaptureReq (1), outputs CaptureTime (TIME_W) and CaptureValid (1): CaptureReq high latches Time into CaptureTime and sets CaptureValid the next cycle; a new CaptureReq overwrites; CaptureValid clears on Load.
REQ-028 Without SYSTEM_TIMER_CAPTURE_EN, those ports and registers SHALL NOT exist; all other behaviour is identical.

Verification
REQ-029 Prescale=3, Enable=1 from reset for 12 cycles -> Time 0,0,0,0,1,...,3 at cycle 12; Tick pulses 3 times, period 4.
REQ-030 TIME_W=16, Load 0xFFFF, Prescale=0 -> next cycle Time=0x0000, Wrap=1 one cycle, Tick=1.
REQ-031 AlarmValue[0]=5, Mask=1, Prescale=0 -> AlarmFlag[0]=1 cycle after Time=5, Irq one cycle later; AlarmClear[0] -> both clear, flag stays 0 while Time stays 5 (Enable=0).
REQ-032 Load 0x0010 on same cycle as prescale terminal count -> Time=0x0010, count=0, no Tick.
REQ-033 Reset asserted mid-count with Time=0x1234 -> all outputs 0 immediately without a clock edge.
REQ-034 With SYSTEM_TIMER_CAPTURE_EN, CaptureReq at Time=7 -> CaptureTime=7, CaptureValid=1 next cycle while Time continues.
